// File: rtl/sram_fifo_pkg.sv
// Shared types and sizes for the SRAM-backed streaming FIFO controller.
// Data width depends on SRAM_FIFO_PARITY_EN (32 data + 4 byte-parity bits, else 36 raw bits).
package sram_fifo_pkg;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int MEM_W  = 36;
  localparam int LVL_W  = ADDR_W + 1;

`ifdef SRAM_FIFO_PARITY_EN
  localparam int DATA_W = 32;
`else
  localparam int DATA_W = 36;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              perr;
  } ob_entry_t;

  // One even-parity bit per byte, bit i covering byte i.
  function automatic logic [3:0] byte_par(input logic [31:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/sram_fifo_obuf.sv
// Two-entry first-word-fall-through buffer that catches SRAM read data.
// slot0 is always the head; slot1 only holds data when cnt == 2.
module sram_fifo_obuf
  import sram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_perr,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_perr,
  output logic [1:0]        cnt
);

  ob_entry_t slot0;
  ob_entry_t slot1;
  ob_entry_t din;

  assign din       = '{data: push_data, perr: push_perr};
  assign head_data = slot0.data;
  assign head_perr = slot0.perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 2'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      if (push && pop) begin
        if (cnt == 2'd2) begin
          slot0 <= slot1;
          slot1 <= din;
        end else begin
          slot0 <= din;
        end
      end else if (push) begin
        if (cnt == 2'd0) begin
          slot0 <= din;
        end else begin
          slot1 <= din;
        end
      end else if (pop) begin
        slot0 <= slot1;
      end
    end
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Streaming FIFO controller for a 1024x36 dual-port SRAM with 1-cycle read latency.
// Define SRAM_FIFO_PARITY_EN to store per-byte parity and expose out_perr.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   level,
  output logic [ADDR_W-1:0] sram_waddr,
  output logic [MEM_W-1:0]  sram_wdata,
  output logic [ADDR_W-1:0] sram_raddr,
  input  logic [MEM_W-1:0]  sram_rdata
`ifdef SRAM_FIFO_PARITY_EN
  ,
  output logic              out_perr
`endif
);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] mem_cnt;
  logic [ADDR_W-1:0] mem_cnt_nxt;
  logic              vld_p1;
  logic [1:0]        ob_cnt;
  logic [1:0]        ob_cnt_nxt;
  logic [2:0]        ob_load;
  logic [LVL_W-1:0]  level_nxt;
  logic              push;
  logic              pop;
  logic              rd_fire;
  logic              cap;
  logic [DATA_W-1:0] cap_data;
  logic              cap_perr;
  logic              head_perr;

  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;
  assign out_valid = (ob_cnt != 2'd0);

  // Buffer slots already claimed after this edge: held + returning - leaving.
  assign ob_load = {1'b0, ob_cnt} + 3'(vld_p1) - 3'(pop);
  assign rd_fire = (mem_cnt != '0) && (ob_load < 3'd2) && !flush;
  assign cap     = vld_p1 && !flush;

  assign mem_cnt_nxt = mem_cnt + ADDR_W'(push) - ADDR_W'(rd_fire);
  assign ob_cnt_nxt  = ob_cnt + 2'(cap) - 2'(pop);
  assign level_nxt   = LVL_W'(mem_cnt_nxt) + LVL_W'(rd_fire) + LVL_W'(ob_cnt_nxt);

  assign sram_waddr = wr_ptr;
  assign sram_raddr = rd_ptr;

`ifdef SRAM_FIFO_PARITY_EN
  assign sram_wdata = {byte_par(in_data), in_data};
  assign cap_data   = sram_rdata[31:0];
  assign cap_perr   = (byte_par(sram_rdata[31:0]) != sram_rdata[35:32]);
  assign out_perr   = head_perr;
`else
  logic unused_head_perr;
  assign sram_wdata       = in_data;
  assign cap_data         = sram_rdata;
  assign cap_perr         = 1'b0;
  assign unused_head_perr = head_perr;
`endif

  // Stage p0 -> p1: read address sampled by the SRAM, data returns next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      vld_p1   <= 1'b0;
      in_ready <= 1'b1;
      level    <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      vld_p1   <= 1'b0;
      in_ready <= 1'b1;
      level    <= '0;
    end else begin
      wr_ptr   <= wr_ptr + ADDR_W'(push);
      rd_ptr   <= rd_ptr + ADDR_W'(rd_fire);
      mem_cnt  <= mem_cnt_nxt;
      vld_p1   <= rd_fire;
      in_ready <= (mem_cnt_nxt != ADDR_W'(DEPTH - 1));
      level    <= level_nxt;
    end
  end

  // Stage p1 -> output buffer.
  sram_fifo_obuf u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (cap),
    .push_data (cap_data),
    .push_perr (cap_perr),
    .pop       (pop),
    .head_data (out_data),
    .head_perr (head_perr),
    .cnt       (ob_cnt)
  );

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed + random bench for sram_fifo_ctrl with a behavioural SRAM and a scoreboard queue.
module tb_sram_fifo_ctrl;
  import sram_fifo_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W:0]   level;
  logic [ADDR_W-1:0] sram_waddr;
  logic [MEM_W-1:0]  sram_wdata;
  logic [ADDR_W-1:0] sram_raddr;
  logic [MEM_W-1:0]  sram_rdata;
`ifdef SRAM_FIFO_PARITY_EN
  logic              out_perr;
`endif

  always #5 clk = ~clk;

  sram_fifo_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .sram_waddr (sram_waddr),
    .sram_wdata (sram_wdata),
    .sram_raddr (sram_raddr),
    .sram_rdata (sram_rdata)
`ifdef SRAM_FIFO_PARITY_EN
    ,
    .out_perr   (out_perr)
`endif
  );

  // Behavioural SRAM: write enable tied on, registered read; optional bit-33 corruption.
  localparam logic [MEM_W-1:0] BIT33 = 36'h2_0000_0000;
  logic [MEM_W-1:0]  mem [DEPTH];
  logic [MEM_W-1:0]  rdata_q = '0;
  logic [ADDR_W-1:0] raddr_q = '0;
  logic              corrupt_en = 1'b0;
  logic [ADDR_W-1:0] corrupt_addr = '0;
  logic              next_perr = 1'b0;

  always @(posedge clk) begin
    mem[sram_waddr] <= sram_wdata;
    rdata_q         <= mem[sram_raddr];
    raddr_q         <= sram_raddr;
  end
  assign sram_rdata = (corrupt_en && raddr_q == corrupt_addr) ? (rdata_q ^ BIT33) : rdata_q;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              perr;
  } exp_t;
  exp_t q[$];

  int total = 0;
  int bad = 0;
  int pops = 0;
  int pushes = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle: inputs set at negedge, handshakes scored, returns 1 time unit after posedge.
  task automatic tick(input logic iv, input logic [DATA_W-1:0] d, input logic ordy, input logic fl);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    if (fl) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        pops++;
        if (q.size() == 0) begin
          check("unexpected_pop", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("pop_data", 64'(out_data), 64'(e.data));
`ifdef SRAM_FIFO_PARITY_EN
          check("pop_perr", 64'(out_perr), 64'(e.perr));
`endif
        end
      end
      if (in_valid && in_ready) begin
        pushes++;
        q.push_back('{data: d, perr: next_perr});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (level != '0 && n < 3000) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    check({tag, "_drain_timeout"}, 64'(n < 3000), 64'd1);
    check({tag, "_queue_empty"}, 64'(q.size()), 64'd0);
    check({tag, "_out_valid_low"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_waddr", 64'(sram_waddr), 64'd0);
    check("rst_raddr", 64'(sram_raddr), 64'd0);
`ifdef SRAM_FIFO_PARITY_EN
    check("rst_out_perr", 64'(out_perr), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single push: out_valid after push edge + 2
    tick(1'b1, DATA_W'(36'h0DEADBEEF), 1'b0, 1'b0);
    check("lat_n0_valid", 64'(out_valid), 64'd0);
    check("lat_n0_level", 64'(level), 64'd1);
    tick(1'b0, '0, 1'b0, 1'b0);
    check("lat_n1_valid", 64'(out_valid), 64'd0);
    tick(1'b0, '0, 1'b0, 1'b0);
    check("lat_n2_valid", 64'(out_valid), 64'd1);
    check("lat_n2_data", 64'(out_data), 64'(DATA_W'(36'h0DEADBEEF)));
    check("lat_n2_level", 64'(level), 64'd1);
    tick(1'b0, '0, 1'b1, 1'b0);
    check("single_level_after_pop", 64'(level), 64'd0);

    // Fill with out_ready low until in_ready drops
    pushes = 0;
    pops = 0;
    n = 0;
    while (in_ready && n < 1100) begin
      tick(1'b1, DATA_W'(32'hA000_0000 + n), 1'b0, 1'b0);
      n++;
    end
    check("fill_accepted", 64'(pushes), 64'd1025);
    check("fill_level", 64'(level), 64'd1025);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    repeat (3) tick(1'b1, DATA_W'(32'h5555_5555), 1'b0, 1'b0);
    check("full_push_ignored", 64'(pushes), 64'd1025);
    check("full_level_hold", 64'(level), 64'd1025);
    drain("fill");
    check("fill_drained", 64'(pops), 64'd1025);
    check("fill_in_ready_back", 64'(in_ready), 64'd1);

    // Streaming push+pop: one word per cycle across pointer wraps
    pushes = 0;
    pops = 0;
    for (int i = 0; i < 4096; i++) begin
      tick(1'b1, DATA_W'(i), 1'b1, 1'b0);
    end
    check("stream_accepted", 64'(pushes), 64'd4096);
    check("stream_pops", 64'(pops), 64'd4093);
    drain("stream");
    check("stream_total_pops", 64'(pops), 64'd4096);

    // Flush with 500 held and a read in flight
    pops = 0;
    for (int i = 0; i < 501; i++) begin
      tick(1'b1, DATA_W'(32'hF000 + i), 1'b0, 1'b0);
    end
    tick(1'b0, '0, 1'b1, 1'b0);
    check("preflush_level", 64'(level), 64'd500);
    tick(1'b1, DATA_W'(32'h0BAD), 1'b1, 1'b1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_level", 64'(level), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    check("postflush_out_valid", 64'(out_valid), 64'd0);
    check("postflush_level", 64'(level), 64'd0);
    pops = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, DATA_W'(32'h1000 + i), 1'b0, 1'b0);
    end
    drain("postflush");
    check("postflush_pops", 64'(pops), 64'd3);

    // Random backpressure, fill-biased then drain-biased
    for (int i = 0; i < 10000; i++) begin
      logic iv;
      logic ordy;
      if (i < 5000) begin
        iv   = ($urandom_range(0, 9) < 9);
        ordy = ($urandom_range(0, 9) < 3);
      end else begin
        iv   = ($urandom_range(0, 9) < 3);
        ordy = ($urandom_range(0, 9) < 9);
      end
      tick(iv, DATA_W'({$urandom, $urandom}), ordy, 1'b0);
      check("rand_level_max", 64'(level <= 11'd1025), 64'd1);
    end
    drain("rand");

    // Asynchronous reset mid-stream
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, DATA_W'(32'hC0DE_0000 + i), 1'b0, 1'b0);
    end
    check("prereset_level", 64'(level), 64'd10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_level", 64'(level), 64'd0);
    check("async_rst_waddr", 64'(sram_waddr), 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef SRAM_FIFO_PARITY_EN
    // Corrupt stored parity of the middle word only
    pops = 0;
    tick(1'b1, 32'h1111_1111, 1'b0, 1'b0);
    corrupt_addr = sram_waddr;
    corrupt_en   = 1'b1;
    next_perr    = 1'b1;
    tick(1'b1, 32'h2222_2222, 1'b0, 1'b0);
    next_perr    = 1'b0;
    tick(1'b1, 32'h3333_3333, 1'b0, 1'b0);
    drain("parity");
    corrupt_en = 1'b0;
    check("parity_pops", 64'(pops), 64'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
